// File: rtl/disp_scan_mux.sv
// rtl/disp_scan_mux.sv - 7-digit scan multiplexer with PWM brightness and ghost blank; option macro DISP_BLINK_EN
module disp_scan_mux #(
  parameter int NDIG      = 7,
  parameter int SCAN_DIV  = 8,
  parameter int BLINK_FRM = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Pulse,
  input  logic [6:0]                  S0disp,
  input  logic [6:0]                  S1disp,
  input  logic [6:0]                  M0disp,
  input  logic [6:0]                  M1disp,
  input  logic [6:0]                  H0disp,
  input  logic [6:0]                  H1disp,
  input  logic [6:0]                  D0disp,
  input  logic [$clog2(SCAN_DIV)-1:0] Bright,
`ifdef DISP_BLINK_EN
  input  logic                        Blink,
`endif
  output logic [6:0]                  SegOut,
  output logic [NDIG-1:0]             DigEn,
  output logic [2:0]                  DigIdx,
  output logic                        FrameDone
);

  localparam int CW = $clog2(SCAN_DIV);

  logic            started_q, started_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [NDIG-1:0] en_q, en_d;
  logic            fd_q, fd_d;
  logic            frame_wrap;
  logic            blank;

  // Last tick of the last digit's dwell: the index is about to wrap to 0.
  assign frame_wrap = Pulse && started_q && (cnt_q == CW'(SCAN_DIV - 1)) &&
                      (idx_q == 3'(NDIG - 1));

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;

  logic [FW-1:0] frm_q, frm_d;
  logic          ph_q, ph_d;

  // Count completed frames; flip the blink phase every BLINK_FRM frames.
  always_comb begin
    frm_d = frm_q;
    ph_d  = ph_q;
    if (Pulse) begin
      if (!Blink) begin
        frm_d = '0;
        ph_d  = 1'b0;
      end else if (frame_wrap) begin
        if (frm_q == FW'(BLINK_FRM - 1)) begin
          frm_d = '0;
          ph_d  = ~ph_q;
        end else begin
          frm_d = frm_q + FW'(1);
        end
      end
    end
  end

  // Blink frame counter and phase registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frm_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      frm_q <= frm_d;
      ph_q  <= ph_d;
    end
  end

  assign blank = Blink & ph_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^BLINK_FRM;
  assign blank      = 1'b0;
`endif

  // Next-state for dwell counter, scan index, captured segments and enables.
  // Enables are computed from the next counter value so they land on the same edge.
  always_comb begin
    started_d = started_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    seg_d     = seg_q;
    en_d      = en_q;
    fd_d      = 1'b0;
    if (Pulse) begin
      if (!started_q) begin
        started_d = 1'b1;
        cnt_d     = '0;
        idx_d     = 3'd0;
      end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_d = '0;
        if (frame_wrap) begin
          idx_d = 3'd0;
          fd_d  = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      if (cnt_d == '0) begin
        case (idx_d)
          3'd0:    seg_d = S0disp;
          3'd1:    seg_d = S1disp;
          3'd2:    seg_d = M0disp;
          3'd3:    seg_d = M1disp;
          3'd4:    seg_d = H0disp;
          3'd5:    seg_d = H1disp;
          3'd6:    seg_d = D0disp;
          default: seg_d = 7'h00;
        endcase
      end

      if ((cnt_d != '0) && (cnt_d <= Bright) && !blank) begin
        en_d = NDIG'(1) << idx_d;
      end else begin
        en_d = '0;
      end
    end
  end

  // Scan state registers; FrameDone is a single-Clk pulse regardless of Pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      started_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      seg_q     <= 7'h00;
      en_q      <= '0;
      fd_q      <= 1'b0;
    end else begin
      started_q <= started_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
      fd_q      <= fd_d;
    end
  end

  assign SegOut    = seg_q;
  assign DigEn     = en_q;
  assign DigIdx    = idx_q;
  assign FrameDone = fd_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// tb/tb_disp_scan_mux.sv - scoreboard and vector-table bench for disp_scan_mux
module tb_disp_scan_mux;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Pulse;
  logic [6:0] s0, s1, m0, m1, h0, h1, d0;
  logic [2:0] bright;
  logic       blink;
  logic [6:0] seg_out;
  logic [6:0] dig_en;
  logic [2:0] dig_idx;
  logic       frame_done;

  disp_scan_mux #(.NDIG(7), .SCAN_DIV(8), .BLINK_FRM(2)) dut (
    .Clk(Clk), .Reset(Reset), .Pulse(Pulse),
    .S0disp(s0), .S1disp(s1), .M0disp(m0), .M1disp(m1),
    .H0disp(h0), .H1disp(h1), .D0disp(d0),
    .Bright(bright),
`ifdef DISP_BLINK_EN
    .Blink(blink),
`endif
    .SegOut(seg_out), .DigEn(dig_en), .DigIdx(dig_idx), .FrameDone(frame_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [6:0] seg;
    logic [6:0] en;
    logic [2:0] idx;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [2:0] br;
    int         on_per_dwell;
  } vec_t;

  exp_t sbq[$];
  exp_t last_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   m_started;
  int   g;
  logic [6:0] m_seg;
  bit   m_blink;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] din(input int i);
    case (i)
      0: return s0;
      1: return s1;
      2: return m0;
      3: return m1;
      4: return h0;
      5: return h1;
      default: return d0;
    endcase
  endfunction

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("SegOut", seg_out, e.seg);
      chk("DigEn", dig_en, e.en);
      chk("DigIdx", dig_idx, e.idx);
      chk("FrameDone", frame_done, e.fd);
    end
  endtask

  task automatic tick();
    exp_t e;
    int cnt, ix;
    bit dark;
    Pulse = 1'b1;
    if (!m_started) begin
      m_started = 1'b1;
      g = 0;
    end else begin
      g++;
    end
    cnt = g % 8;
    ix  = (g / 8) % 7;
    if (cnt == 0) m_seg = din(ix);
    dark  = m_blink && (((g / 56) / 2) % 2 == 1);
    e.seg = m_seg;
    e.idx = 3'(ix);
    e.en  = (cnt >= 1 && cnt <= int'(bright) && !dark) ? 7'(1 << ix) : 7'h00;
    e.fd  = (g > 0) && (g % 56 == 0);
    sbq.push_back(e);
    last_e = e;
    @(posedge Clk);
    #1;
    Pulse = 1'b0;
    check_out();
  endtask

  task automatic idle();
    exp_t e;
    Pulse = 1'b0;
    e = last_e;
    e.fd = 1'b0;
    sbq.push_back(e);
    last_e = e;
    @(posedge Clk);
    #1;
    check_out();
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    g = 0;
    m_seg = 7'h00;
    sbq.delete();
    last_e = '{seg: 7'h00, en: 7'h00, idx: 3'd0, fd: 1'b0};
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_SegOut"}, seg_out, 7'h00);
    chk({tag, "_DigEn"}, dig_en, 7'h00);
    chk({tag, "_DigIdx"}, dig_idx, 3'd0);
    chk({tag, "_FrameDone"}, frame_done, 1'b0);
  endtask

  vec_t vecs[5];

  initial begin
    int on_cnt, fd_cnt, guard;
    int frame_on[7];
    int frame_exp[7];

    vecs[0] = '{br: 3'd7, on_per_dwell: 7};
    vecs[1] = '{br: 3'd2, on_per_dwell: 2};
    vecs[2] = '{br: 3'd0, on_per_dwell: 0};
    vecs[3] = '{br: 3'd5, on_per_dwell: 5};
    vecs[4] = '{br: 3'd1, on_per_dwell: 1};

    s0 = 7'h01; s1 = 7'h02; m0 = 7'h03; m1 = 7'h04;
    h0 = 7'h05; h1 = 7'h06; d0 = 7'h07;
    bright = 3'd7;
    blink = 1'b0;
    m_blink = 1'b0;
    Pulse = 1'b0;
    Reset = 1'b1;
    model_reset();
    #12;
    check_reset_state("por");
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Asynchronous reset mid-dwell at index 3.
    repeat (28) tick();
    chk("pre_reset_idx", dig_idx, 3'd3);
    #3;
    Reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();

    // One full frame per brightness record.
    for (int v = 0; v < 5; v++) begin
      bright = vecs[v].br;
      on_cnt = 0;
      fd_cnt = 0;
      for (int t = 0; t < 56; t++) begin
        tick();
        if (dig_en != 7'h00) on_cnt++;
        if (frame_done) fd_cnt++;
      end
      chk($sformatf("on_ticks_br%0d", vecs[v].br), on_cnt, vecs[v].on_per_dwell * 7);
      chk($sformatf("frames_br%0d", vecs[v].br), fd_cnt, (v == 0) ? 0 : 1);
    end

    // Mid-dwell input change on index 2 must wait for the next index-2 dwell.
    bright = 3'd7;
    guard = 0;
    while (!((g % 56) / 8 == 2 && g % 8 == 4) && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_idx2_cnt4", guard < 200, 1'b1);
    m0 = 7'h7F;
    repeat (3) tick();
    chk("held_old_seg", seg_out, 7'h03);
    guard = 0;
    while (!((g % 56) / 8 == 2 && g % 8 == 0) && guard < 200) begin
      tick();
      guard++;
    end
    chk("new_seg_next_dwell", seg_out, 7'h7F);
    m0 = 7'h03;

    // Pulse held low for 20 cycles mid-dwell, then resume.
    guard = 0;
    while (g % 8 != 3 && guard < 20) begin
      tick();
      guard++;
    end
    repeat (20) idle();
    repeat (10) tick();

`ifdef DISP_BLINK_EN
    // Blink with BLINK_FRM=2: two lit frames, two dark frames, then released.
    Reset = 1'b1;
    #1;
    check_reset_state("blink_rst");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    bright = 3'd7;
    blink = 1'b1;
    m_blink = 1'b1;
    frame_exp = '{49, 49, 0, 0, 49, 49, 49};
    for (int f = 0; f < 7; f++) begin
      if (f == 6) begin
        blink = 1'b0;
        m_blink = 1'b0;
      end
      frame_on[f] = 0;
      for (int t = 0; t < 56; t++) begin
        tick();
        if (dig_en != 7'h00) frame_on[f]++;
      end
      chk($sformatf("blink_frame%0d", f), frame_on[f], frame_exp[f]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
